// File: rtl/ft2_pkg.sv
// Shared types and constants for the FT2 transmit path.
// Skid depth, byte type and the default idle-flush interval.
package ft2_pkg;

    localparam int FT2_SKID_DEPTH = 3;
    localparam int FT2_IDLE_FLUSH = 16;

    typedef logic [7:0] ft2_byte_t;

endpackage

// File: rtl/ft2_skid_buf.sv
// Three-entry circular skid buffer between FIFO read data and FT2232H bus.
// Ports: clk, rst (sync, active-high); push/wdata write at tail; pop advances
// head; occ is current occupancy, occ_next and next_data describe the buffer
// after this edge's push/pop (next_data is don't-care when occ_next is 0).
module ft2_skid_buf
    import ft2_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  ft2_byte_t wdata,
    output logic [1:0] occ,
    output logic [1:0] occ_next,
    output ft2_byte_t next_data
);

    ft2_byte_t  mem [FT2_SKID_DEPTH];
    logic [1:0] head;
    logic [1:0] tail;
    logic [1:0] head_next;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'(FT2_SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        occ_next  = occ + {1'b0, push} - {1'b0, pop};
        head_next = pop ? wrap_inc(head) : head;
        // Buffer drains to empty before the push lands: the new head is
        // the byte being written this edge, not yet in mem.
        if (occ == {1'b0, pop}) begin
            next_data = wdata;
        end else begin
            next_data = mem[head_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= 2'd0;
            tail <= 2'd0;
            occ  <= 2'd0;
        end else begin
            if (push) begin
                tail <= wrap_inc(tail);
            end
            head <= head_next;
            occ  <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/ft2_tx_bridge.sv
// Drains the FT2 byte FIFO into the FT2232H sync 245-FIFO write port.
// Ports: clk/rst (sync, active-high); fifo_empty, fifo_rd_en, fifo_rd_data
// (1-cycle read latency); ft_txe_n, ft_wr_n, ft_data, ft_siwu_n to the chip;
// tx_bytes counts accepted bytes mod 2^16.
// Build option FT2_TX_SIWU_EN enables the idle send-immediate pulse.
module ft2_tx_bridge
    import ft2_pkg::*;
#(
    parameter int IDLE_FLUSH = FT2_IDLE_FLUSH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        ft_txe_n,
    output logic        ft_wr_n,
    output logic [7:0]  ft_data,
    output logic        ft_siwu_n,
    output logic [15:0] tx_bytes
);

    if (IDLE_FLUSH < 2 || IDLE_FLUSH > 65535) begin : g_bad_flush
        $error("IDLE_FLUSH must be in 2..65535");
    end

    logic       inflight;
    logic       accept;
    logic       drive_next;
    logic [1:0] occ;
    logic [1:0] occ_next;
    logic [2:0] committed;
    ft2_byte_t  next_data;

    // Bytes already owed to the buffer: stored plus the read on its way.
    assign committed  = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = !fifo_empty && (committed < 3'(FT2_SKID_DEPTH));
    assign accept     = !ft_wr_n && !ft_txe_n;
    assign drive_next = (occ_next != 2'd0) && !ft_txe_n;

    ft2_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .pop       (accept),
        .wdata     (fifo_rd_data),
        .occ       (occ),
        .occ_next  (occ_next),
        .next_data (next_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            ft_wr_n  <= 1'b1;
            ft_data  <= 8'h00;
            tx_bytes <= 16'h0000;
        end else begin
            inflight <= fifo_rd_en;
            ft_wr_n  <= !drive_next;
            // Data bus only moves when a write is presented.
            if (drive_next) begin
                ft_data <= next_data;
            end
            if (accept) begin
                tx_bytes <= tx_bytes + 16'd1;
            end
        end
    end

`ifdef FT2_TX_SIWU_EN
    logic [15:0] idle_cnt;
    logic [15:0] idle_next;
    logic        armed;
    logic        fire;

    always_comb begin
        idle_next = idle_cnt;
        if (accept) begin
            idle_next = 16'd0;
        end else if (occ == 2'd0 && fifo_empty &&
                     idle_cnt != 16'(IDLE_FLUSH)) begin
            idle_next = idle_cnt + 16'd1;
        end
        fire = armed && (idle_next == 16'(IDLE_FLUSH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= 16'd0;
            armed     <= 1'b0;
            ft_siwu_n <= 1'b1;
        end else begin
            idle_cnt  <= idle_next;
            ft_siwu_n <= !fire;
            if (accept) begin
                armed <= 1'b1;
            end else if (fire) begin
                armed <= 1'b0;
            end
        end
    end
`else
    assign ft_siwu_n = 1'b1;
`endif

endmodule

// File: tb/tb_ft2_tx_bridge.sv
// Self-checking bench for ft2_tx_bridge: FIFO and FT2232H models with a
// byte-order scoreboard, plus directed timing scenarios and random traffic.
module tb_ft2_tx_bridge;
    import ft2_pkg::*;

    localparam int IDLE_FLUSH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        ft_txe_n = 1'b1;
    logic        ft_wr_n;
    logic [7:0]  ft_data;
    logic        ft_siwu_n;
    logic [15:0] tx_bytes;

    ft2_tx_bridge #(.IDLE_FLUSH(IDLE_FLUSH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .ft_txe_n     (ft_txe_n),
        .ft_wr_n      (ft_wr_n),
        .ft_data      (ft_data),
        .ft_siwu_n    (ft_siwu_n),
        .tx_bytes     (tx_bytes)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    ft2_byte_t fifo_q[$];
    ft2_byte_t exp_q[$];
    bit          rd_pend = 1'b0;
    logic [15:0] acc_model = 16'd0;
    int          acc_total = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          refused = 0;
    int          siwu_lows = 0;
    int          siwu_cyc = 0;
    bit          wr_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then judge what
    // the next rising edge will do (read issue, byte accept).
    task automatic step(input bit txe, input bit r);
        bit        was_rst;
        ft2_byte_t b;
        @(negedge clk);
        cyc++;
        was_rst  = rst;
        rst      = r;
        ft_txe_n = txe;
        if (was_rst) begin
            exp_q.delete();
            acc_model = 16'd0;
        end
        if (rd_pend && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            fifo_rd_data = b;
            if (!was_rst) exp_q.push_back(b);
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
        check("tx_bytes", 32'(tx_bytes), 32'(acc_model));
        check("read_ahead", 32'(exp_q.size() <= 3), 32'd1);
        check("rd_en_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (was_rst) check("rst_wr_n", 32'(ft_wr_n), 32'd1);
        rd_pend = fifo_rd_en;
        if (!ft_wr_n && !ft_txe_n && !rst) begin
            if (exp_q.size() == 0) check("spurious_wr", 32'd1, 32'd0);
            else check("ft_data", 32'(ft_data), 32'(exp_q.pop_front()));
            acc_model++;
            acc_total++;
            last_acc_cyc = cyc;
        end
        if (!ft_wr_n && ft_txe_n && !rst) refused++;
        wr_low = !ft_wr_n;
        if (!ft_siwu_n) begin
            siwu_lows++;
            siwu_cyc = cyc;
        end
    endtask

    task automatic drain(input int budget, input int stall_pct);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || rd_pend) &&
               n < budget) begin
            step($urandom_range(99, 0) < stall_pct, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("idle_wr_n", 32'(ft_wr_n), 32'd1);
    endtask

    initial begin
        bit wl[22];
        int base;
        int stall;
        bit stalled;
        int n;
        int lows;
        bit prev;
        int pushed;

        // Reset values
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("rst_wr_n0", 32'(ft_wr_n), 32'd1);
        check("rst_siwu", 32'(ft_siwu_n), 32'd1);
        check("rst_data", 32'(ft_data), 32'h00);
        check("rst_count", 32'(tx_bytes), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // Reset then stream 0x00..0x0F: exact WR# window
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        for (int k = 0; k < 22; k++) begin
            step(1'b0, 1'b0);
            if (k == 0) check("t1_rd_en0", 32'(rd_pend), 32'd1);
            wl[k] = wr_low;
        end
        for (int k = 0; k < 22; k++)
            check($sformatf("t1_wr_low_%0d", k), 32'(wl[k]),
                  32'(k >= 2 && k <= 17));
        check("t1_count", 32'(tx_bytes), 32'd16);

        // Back-pressure: TXE# high for 5 cycles at the 10th accept
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'($urandom));
        base = acc_total;
        stall = 0;
        stalled = 1'b0;
        refused = 0;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || rd_pend) &&
               n < 300) begin
            if (!stalled && acc_total - base == 9) begin
                stall = 5;
                stalled = 1'b1;
            end
            step(stall > 0, 1'b0);
            if (stall > 0) stall--;
            n++;
        end
        check("t2_timeout", 32'(n < 300), 32'd1);
        check("t2_stalled", 32'(stalled), 32'd1);
        check("t2_refused", 32'(refused), 32'd1);
        check("t2_bytes", 32'(acc_total - base), 32'd32);
        drain(20, 0);

        // Trickle: one byte every 4 cycles, WR# low one cycle per byte
        base = acc_total;
        lows = 0;
        prev = 1'b0;
        for (int k = 0; k < 44; k++) begin
            if (k % 4 == 0 && k < 40) fifo_q.push_back(8'($urandom));
            step(1'b0, 1'b0);
            if (wr_low) begin
                lows++;
                check("t3_single", 32'(prev), 32'd0);
            end
            prev = wr_low;
        end
        check("t3_lows", 32'(lows), 32'd10);
        check("t3_bytes", 32'(acc_total - base), 32'd10);

        // Reset mid-stream after 5 bytes with two bytes buffered
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'($urandom));
        base = acc_total;
        n = 0;
        while (acc_total - base < 5 && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("t4_timeout", 32'(n < 50), 32'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("t4_wr_n", 32'(ft_wr_n), 32'd1);
        check("t4_count", 32'(tx_bytes), 32'd0);
        drain(200, 0);

        // Random traffic against the scoreboard
        pushed = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3, 0) == 0 && pushed < 150) begin
                fifo_q.push_back(8'($urandom));
                pushed++;
            end
            step($urandom_range(99, 0) < 30, 1'b0);
        end
        drain(600, 30);

        // Counter wrap
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 65535; i++) fifo_q.push_back(8'($urandom));
        drain(70000, 0);
        check("t5_full", 32'(tx_bytes), 32'h0000ffff);
        fifo_q.push_back(8'hA5);
        drain(20, 0);
        check("t5_wrap", 32'(tx_bytes), 32'd0);

        // Idle send-immediate
        siwu_lows = 0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
        drain(20, 0);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
`ifdef FT2_TX_SIWU_EN
        check("t6_pulses", 32'(siwu_lows), 32'd1);
        check("t6_delay", 32'(siwu_cyc - last_acc_cyc), 32'(IDLE_FLUSH + 1));
`else
        check("t6_pulses", 32'(siwu_lows), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ft2_tx_bridge.md
# ft2_tx_bridge

Drains the 2048-byte FT2 byte FIFO into the FT2232H synchronous 245-FIFO write port. It issues FIFO reads, absorbs the one-cycle FIFO read latency and TXE# back-pressure in a 3-entry skid buffer, and drives WR#/DATA at one byte per clock once the pipeline is primed. It sits directly downstream of the FT2 FIFO read port, in the 60 MHz FT2232H CLKOUT domain.

## Interface
- IDLE_FLUSH, 16: idle cycles before a send-immediate pulse (SIWU build only); valid range 2..65535.
- clk  in  1  FT2232H CLKOUT, 60 MHz; the FIFO read side shares this clock.
- rst  in  1  reset rst, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe. Asserted only while fifo_empty=0. Data appears on fifo_rd_data in the following cycle.
- fifo_rd_data  in  8  FIFO read data.
- ft_txe_n  in  1  FT2232H TXE#; low means the chip accepts a byte at this edge.
- ft_wr_n  out  1  FT2232H WR#, registered.
- ft_data  out  8  FT2232H data bus (write direction only), registered.
- ft_siwu_n  out  1  FT2232H SIWU#, registered.
- tx_bytes  out  16  Count of bytes accepted by the FT2232H; wraps modulo 2^16.

## Operation
- **Skid buffer.** Circular buffer, 3 × 8 bits, with 2-bit head, tail and occupancy `occ` (0..3). One flag, `inflight`, marks an outstanding FIFO read.
- **Read issue.** `fifo_rd_en = !fifo_empty && (occ + inflight) < 3`.
  - `inflight` is set the cycle after `fifo_rd_en`.
  - When `inflight` is set, `fifo_rd_data` is captured at the tail on that edge.
- **Accept.** A byte is accepted on an edge where both `ft_wr_n=0` and `ft_txe_n=0` are sampled.
  - On accept: head advances, `occ` decrements, `tx_bytes` increments.
  - If WR# is low but TXE# is sampled high, nothing is consumed. The same byte stays on `ft_data` until it is accepted.
- **Simultaneous events.** Capture and accept on the same edge leave `occ` unchanged. `occ` never exceeds 3 and never underflows.
- **Next-cycle drive.** `ft_wr_n_next = !(occ_next > 0 && !ft_txe_n)`. `ft_data_next` is the head entry after this edge's accept and capture.
- **No idle toggling.** `ft_data` holds its last value while WR# is high.
- **Reset mid-operation.** Buffer contents and any in-flight byte are discarded; the FIFO-side byte is lost, which is acceptable. Firmware reissues the transfer.

## Timing
- **Reset values:** `ft_wr_n=1`, `ft_siwu_n=1`, `ft_data=8'h00`, `fifo_rd_en=0` (combinational, with `occ=0` and `inflight=0`), `tx_bytes=0`.
- **Latency.** If `fifo_rd_en` is high in cycle t:
  - data is captured at the end of cycle t+1;
  - WR# is low in cycle t+2 (provided TXE# was low at the end of t+1);
  - earliest accept is at the end of cycle t+2.
- **Steady-state throughput.** With TXE# low and the FIFO non-empty, one byte per clock. Steady state is `occ=1`, `inflight=1`.
- **TXE# high for N cycles.** WR# goes high one cycle after TXE# is sampled high. At most one attempted write is refused per stall.
  - Reads stop once `occ + inflight = 3`.
  - No byte is lost or duplicated.
- **Empty FIFO.** No reads are issued. WR# goes high the cycle after the last accept when `occ_next=0`.

## Configuration
- **`FT2_TX_SIWU_EN` defined:** a 16-bit idle counter runs.
  - It clears on every accept and counts while `occ=0` and `fifo_empty=1`.
  - When it reaches IDLE_FLUSH after at least one accept since the last flush, `ft_siwu_n` pulses low for exactly one cycle, forcing the FT2232H to send a short USB packet.
  - The counter saturates and no further pulse fires until a new accept occurs.
- **Undefined:** `ft_siwu_n` is tied to 1; no counter logic is present.

## Structure
- **Shared package `ft2_pkg`:**
  - `FT2_SKID_DEPTH=3`;
  - `ft2_byte_t` (`logic[7:0]`);
  - default `IDLE_FLUSH`.
- **Sub-module `ft2_skid_buf`:** the 3-entry circular buffer (push, pop, occupancy, head data). The top level owns the FIFO and FT2232H handshakes, the counter and SIWU.

## Test plan
- **Reset then stream.** Reset, preload FIFO with 0x00..0x0F, TXE# low -> `fifo_rd_en` in cycle 0; WR# low from cycle 2 to 17; `ft_data` 0x00..0x0F in order; `tx_bytes=16`; WR# high in cycle 18.
- **Back-pressure.** 32-byte stream, TXE# high for 5 cycles starting at the 10th accept -> no more than 3 bytes read ahead; the byte on the refused edge is re-presented; output sequence is intact with no gap or duplicate.
- **Trickle FIFO.** FIFO gets 1 byte every 4 cycles -> each byte appears on `ft_data` with WR# low for exactly 1 cycle; `fifo_rd_en` is never high while `fifo_empty=1`.
- **Reset mid-stream.** `rst` after 5 of 20 bytes with `occ=2` -> next cycle WR#=1, `tx_bytes=0`, `occ=0`; resumes cleanly from the next FIFO byte.
- **Wrap.** `tx_bytes` preset via 65535 accepts, one more byte -> reads 0.
- **SIWU (`FT2_TX_SIWU_EN`).** 3 bytes sent, then FIFO empty, IDLE_FLUSH=16 -> `ft_siwu_n` low for exactly one cycle, 16 cycles after the last accept. No second pulse while idle continues.
